// File: rtl/clk_enable_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_enable_pkg
// Shared constants and helpers for the fractional clock-enable generator.
//   ACC_W_DEF            default phase accumulator width
//   STEP_25M175_AT_100M  step for a 25.175 MHz enable from a 100 MHz clock
//   STEP_25M_AT_100M     step for a 25 MHz enable from a 100 MHz clock
//   step_for()           rounded step for f_out from f_clk at ACC_W_DEF bits
//   ch_idx_w()           width of a channel index (never below 1)
// -----------------------------------------------------------------------------
package clk_enable_pkg;

  localparam int ACC_W_DEF = 32;

  localparam logic [31:0] STEP_25M175_AT_100M = 32'd1081258017;
  localparam logic [31:0] STEP_25M_AT_100M    = 32'h4000_0000;

  // step = round(f_out * 2^ACC_W / f_clk); the half-divisor term does the rounding.
  function automatic logic [ACC_W_DEF-1:0] step_for(input longint unsigned f_out_hz,
                                                    input longint unsigned f_clk_hz);
    longint unsigned num;
    num = (f_out_hz << ACC_W_DEF) + (f_clk_hz >> 1);
    return ACC_W_DEF'(num / f_clk_hz);
  endfunction

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/clk_enable_gen_if.sv
// -----------------------------------------------------------------------------
// clk_enable_gen_if
// Control/status bundle of the clock-enable generator.
//   wr_en, wr_ch, wr_step  step write strobe, target channel, new step
//   phase_rst              resynchronise all accumulators
//   tick                   per-channel one-cycle enable pulses
//   ch_locked, locked      per-channel and global lock status
// master: the controller driving writes; slave: the generator.
// -----------------------------------------------------------------------------
interface clk_enable_gen_if
  import clk_enable_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = ACC_W_DEF
);
  localparam int CH_W = ch_idx_w(NUM_CH);

  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [ACC_W-1:0]  wr_step;
  logic              phase_rst;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] ch_locked;
  logic              locked;

  modport master (
    output wr_en, wr_ch, wr_step, phase_rst,
    input  tick, ch_locked, locked
  );

  modport slave (
    input  wr_en, wr_ch, wr_step, phase_rst,
    output tick, ch_locked, locked
  );

endinterface

// File: rtl/clk_enable_gen_channel.sv
// -----------------------------------------------------------------------------
// clk_enable_channel
// One phase-accumulator enable channel with a single pending-step slot.
//   i_clk, i_rst   system clock, synchronous active-high reset
//   i_started      startup period elapsed; gates ticks and lock
//   i_wr           write strobe for this channel (already decoded)
//   i_wr_step      step value carried by the write
//   i_phase_rst    zero the accumulator and apply any pending step now
//   o_tick         registered one-cycle enable pulse
//   o_locked       running at the programmed step with no write pending
// -----------------------------------------------------------------------------
module clk_enable_channel #(
  parameter int               ACC_W        = 32,
  parameter logic [ACC_W-1:0] DEFAULT_STEP = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_started,
  input  logic             i_wr,
  input  logic [ACC_W-1:0] i_wr_step,
  input  logic             i_phase_rst,
  output logic             o_tick,
  output logic             o_locked
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_step;
  logic [ACC_W-1:0] r_pend_step;
  logic             r_pending;
  logic             r_tick_p1;
  logic             r_locked;

  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic             w_apply;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_step};
  assign w_carry = w_sum[ACC_W];

  // A pending step is swapped in only at a period boundary so no enable period
  // is ever shortened or stretched. A zero step never carries, so it would
  // otherwise wait forever; switch it on the next cycle instead.
  assign w_apply = r_pending & (w_carry | (r_step == '0));

  // ---- stage p0 -> p1: accumulate, register tick and lock ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc     <= '0;
      r_step    <= DEFAULT_STEP;
      r_pending <= 1'b0;
      r_tick_p1 <= 1'b0;
      r_locked  <= 1'b0;
    end else if (i_phase_rst) begin
      // Resync: a write in the same cycle goes straight into step.
      r_acc     <= '0;
      r_tick_p1 <= 1'b0;
      r_pending <= 1'b0;
      r_locked  <= i_started;
      if (i_wr) begin
        r_step <= i_wr_step;
      end else if (r_pending) begin
        r_step <= r_pend_step;
      end
    end else begin
      r_acc     <= w_sum[ACC_W-1:0];
      // The tick of the boundary cycle still belongs to the old step.
      r_tick_p1 <= w_carry & i_started;
      if (w_apply) begin
        r_step <= r_pend_step;
      end
      // A write landing on the switch cycle stays pending for the next boundary.
      if (i_wr) begin
        r_pending <= 1'b1;
        r_locked  <= 1'b0;
      end else if (w_apply) begin
        r_pending <= 1'b0;
        r_locked  <= i_started;
      end else begin
        r_locked  <= i_started & ~r_pending;
      end
    end
  end

  // Pending slot holds data only; its validity lives in r_pending.
  always_ff @(posedge i_clk) begin
    if (i_wr && !i_phase_rst) begin
      r_pend_step <= i_wr_step;
    end
  end

  assign o_tick   = r_tick_p1;
  assign o_locked = r_locked;

endmodule

// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
// Runtime-programmable fractional clock-enable generator, NUM_CH channels.
// Average tick rate of channel i = f_clk * step[i] / 2^ACC_W.
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   bus (slave)    wr_en/wr_ch/wr_step step writes, phase_rst resync,
//                  tick[NUM_CH] enables, ch_locked[NUM_CH], locked
// Parameters: NUM_CH (1..16), ACC_W, DEFAULT_STEP (packed per channel, ch0 in
// the low bits), STARTUP_CYCLES (1..65535) before any tick may assert.
// -----------------------------------------------------------------------------
module clk_enable_gen
  import clk_enable_pkg::*;
#(
  parameter int                      NUM_CH         = 4,
  parameter int                      ACC_W          = ACC_W_DEF,
  parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_STEP   = {NUM_CH{STEP_25M175_AT_100M}},
  parameter int                      STARTUP_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  clk_enable_gen_if.slave  bus
);

  localparam int              CH_W    = ch_idx_w(NUM_CH);
  localparam int              CNT_W   = $clog2(STARTUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARTUP_CYCLES);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_locked;
  logic              w_started;
  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_ch_locked;

  // ---- startup counter: counts up once, then holds ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_started = (r_cnt == CNT_MAX);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      // Only existing channels get a decode line, so an out-of-range index
      // matches nothing and the write is dropped.
      assign w_wr[g] = bus.wr_en && (bus.wr_ch == CH_W'(g));

      clk_enable_channel #(
        .ACC_W        (ACC_W),
        .DEFAULT_STEP (DEFAULT_STEP[g*ACC_W +: ACC_W])
      ) u_ch (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_started   (w_started),
        .i_wr        (w_wr[g]),
        .i_wr_step   (bus.wr_step),
        .i_phase_rst (bus.phase_rst),
        .o_tick      (w_tick[g]),
        .o_locked    (w_ch_locked[g])
      );
    end
  endgenerate

  // ---- global lock: registered reduction of the per-channel lock bits ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_locked <= 1'b0;
    end else begin
      r_locked <= w_started & (&w_ch_locked);
    end
  end

  assign bus.tick      = w_tick;
  assign bus.ch_locked = w_ch_locked;
  assign bus.locked    = r_locked;

endmodule

// File: tb/tb_clk_enable_gen.sv
module tb_clk_enable_gen;
  import clk_enable_pkg::*;

  localparam int NCH = 2;
  localparam int W   = 8;
  localparam int S   = 4;
  localparam int MOD = 1 << W;
  localparam logic [NCH*W-1:0] DSTEP = {8'd96, 8'd64};

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  clk_enable_gen_if #(.NUM_CH(NCH), .ACC_W(W)) bus ();
  clk_enable_gen_if #(.NUM_CH(1), .ACC_W(32)) bus32 ();

  clk_enable_gen #(.NUM_CH(NCH), .ACC_W(W), .DEFAULT_STEP(DSTEP), .STARTUP_CYCLES(S)) dut (
    .i_clk (clk), .i_rst (rst), .bus (bus)
  );

  clk_enable_gen #(.NUM_CH(1)) dut32 (
    .i_clk (clk), .i_rst (rst2), .bus (bus32)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel phase in integers, rate rules applied directly.
  int       m_acc   [NCH];
  int       m_step  [NCH];
  int       m_pstep [NCH];
  bit       m_pend  [NCH];
  bit [1:0] m_tick;
  bit [1:0] m_chl;
  bit       m_lk;
  int       m_cnt;

  task automatic model_update();
    bit st;
    bit [1:0] chl_old;
    int sum;
    bit carry, apply, wr_i;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = 0; m_step[i] = int'(DSTEP[i*W +: W]); m_pend[i] = 0;
      end
      m_tick = 0; m_chl = 0; m_lk = 0; m_cnt = 0;
    end else begin
      st      = (m_cnt == S);
      chl_old = m_chl;
      m_lk    = st && (chl_old == 2'b11);
      for (int i = 0; i < NCH; i++) begin
        wr_i = bus.wr_en && (int'(bus.wr_ch) == i);
        if (bus.phase_rst) begin
          if (wr_i) m_step[i] = int'(bus.wr_step);
          else if (m_pend[i]) m_step[i] = m_pstep[i];
          m_acc[i] = 0; m_tick[i] = 0; m_pend[i] = 0; m_chl[i] = st;
        end else begin
          sum       = m_acc[i] + m_step[i];
          carry     = (sum >= MOD);
          m_acc[i]  = sum % MOD;
          m_tick[i] = carry && st;
          apply     = m_pend[i] && (carry || m_step[i] == 0);
          if (apply) m_step[i] = m_pstep[i];
          if (wr_i) begin
            m_pstep[i] = int'(bus.wr_step); m_pend[i] = 1; m_chl[i] = 0;
          end else if (apply) begin
            m_pend[i] = 0; m_chl[i] = st;
          end else begin
            m_chl[i] = st && !m_pend[i];
          end
        end
      end
      if (m_cnt < S) m_cnt++;
    end
  endtask

  // Advance one clock: model follows the edge, outputs settle by the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_step = '0; bus.phase_rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++;
      if (bus.tick !== 2'b00 || bus.ch_locked !== 2'b00 || bus.locked !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: tick=%b ch_locked=%b locked=%b, required all 0",
                 bus.tick, bus.ch_locked, bus.locked);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_startup();
    int c0 = 0, c1 = 0, last0 = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      checks++;
      if (bus.tick !== m_tick || bus.ch_locked !== m_chl || bus.locked !== m_lk) begin
        errors++;
        $display("FAIL startup_model k=%0d: tick=%b/%b ch_locked=%b/%b locked=%b/%b (got/required)",
                 k, bus.tick, m_tick, bus.ch_locked, m_chl, bus.locked, m_lk);
      end
      if (k <= S) begin
        checks++;
        if (bus.tick !== 2'b00) begin
          errors++;
          $display("FAIL startup_mask k=%0d: tick=%b, required 00", k, bus.tick);
        end
      end
      if (k == S + 2) begin
        checks++;
        if (bus.locked !== 1'b1) begin
          errors++;
          $display("FAIL startup_locked: locked=%b, required 1", bus.locked);
        end
      end
      if (k > S + 8 && k <= S + 24) begin
        c0 += int'(bus.tick[0]); c1 += int'(bus.tick[1]);
      end
      if (bus.tick[0] === 1'b1) begin
        if (last0 >= 0) begin
          checks++;
          if (k - last0 != 4) begin
            errors++;
            $display("FAIL ch0_interval k=%0d: interval=%0d, required 4", k, k - last0);
          end
        end
        last0 = k;
      end
    end
    checks++;
    if (c0 != 4) begin errors++; $display("FAIL ch0_rate: %0d ticks per 16, required 4", c0); end
    checks++;
    if (c1 != 6) begin errors++; $display("FAIL ch1_rate: %0d ticks per 16, required 6", c1); end
  endtask

  task automatic test_rate_switch();
    int c0 = 0, c1 = 0, k = 0;
    while (m_acc[0] != 64 && k < 8) begin cyc(); k++; end
    checks++;
    if (m_acc[0] != 64) begin errors++; $display("FAIL switch_align: phase never reached 64"); end
    bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_step = 8'd128;
    cyc();
    drive_idle();
    checks++;
    if (bus.ch_locked[0] !== 1'b0) begin
      errors++; $display("FAIL switch_unlock: ch_locked[0]=%b, required 0", bus.ch_locked[0]);
    end
    cyc();
    checks++;
    if (bus.locked !== 1'b0 || bus.tick[0] !== 1'b0) begin
      errors++; $display("FAIL switch_pending: locked=%b tick0=%b, required 0 0", bus.locked, bus.tick[0]);
    end
    cyc();
    checks++;
    if (bus.tick[0] !== 1'b1 || bus.ch_locked[0] !== 1'b1) begin
      errors++; $display("FAIL switch_boundary: tick0=%b ch_locked0=%b, required 1 1", bus.tick[0], bus.ch_locked[0]);
    end
    for (int j = 0; j < 16; j++) begin
      cyc();
      checks++;
      if (bus.tick !== m_tick || bus.ch_locked !== m_chl || bus.locked !== m_lk) begin
        errors++;
        $display("FAIL switch_model j=%0d: tick=%b/%b ch_locked=%b/%b locked=%b/%b (got/required)",
                 j, bus.tick, m_tick, bus.ch_locked, m_chl, bus.locked, m_lk);
      end
      c0 += int'(bus.tick[0]); c1 += int'(bus.tick[1]);
    end
    checks++;
    if (c0 != 8) begin errors++; $display("FAIL switch_ch0_rate: %0d per 16, required 8", c0); end
    checks++;
    if (c1 != 6) begin errors++; $display("FAIL switch_ch1_rate: %0d per 16, required 6", c1); end
  endtask

  task automatic test_overwrite();
    int c1 = 0, k = 0;
    bit seen = 0;
    while (m_acc[1] >= 64 && k < 8) begin cyc(); k++; end
    bus.wr_en = 1'b1; bus.wr_ch = 1'b1; bus.wr_step = 8'd32;
    cyc();
    bus.wr_step = 8'd160;
    cyc();
    drive_idle();
    checks++;
    if (bus.ch_locked[1] !== 1'b0) begin
      errors++; $display("FAIL overwrite_unlock: ch_locked[1]=%b, required 0", bus.ch_locked[1]);
    end
    for (int j = 0; j < 8 && !seen; j++) begin
      cyc();
      seen = (bus.tick[1] === 1'b1);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL overwrite_timeout: no ch1 boundary within 8 cycles"); end
    for (int j = 0; j < 16; j++) begin
      cyc();
      checks++;
      if (bus.tick !== m_tick || bus.ch_locked !== m_chl || bus.locked !== m_lk) begin
        errors++;
        $display("FAIL overwrite_model j=%0d: tick=%b/%b ch_locked=%b/%b locked=%b/%b (got/required)",
                 j, bus.tick, m_tick, bus.ch_locked, m_chl, bus.locked, m_lk);
      end
      c1 += int'(bus.tick[1]);
    end
    checks++;
    if (c1 != 10) begin errors++; $display("FAIL overwrite_rate: %0d per 16, required 10", c1); end
  endtask

  task automatic test_phase_rst();
    int c0 = 0;
    bus.phase_rst = 1'b1; bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_step = 8'd0;
    cyc();
    drive_idle();
    checks++;
    if (bus.tick !== 2'b00 || bus.ch_locked !== 2'b11) begin
      errors++; $display("FAIL phase_rst: tick=%b ch_locked=%b, required 00 11", bus.tick, bus.ch_locked);
    end
    cyc();
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++; $display("FAIL phase_rst_locked: locked=%b, required 1", bus.locked);
    end
    for (int j = 0; j < 20; j++) begin
      cyc();
      checks++;
      if (bus.tick !== m_tick || bus.ch_locked !== m_chl || bus.locked !== m_lk) begin
        errors++;
        $display("FAIL phase_model j=%0d: tick=%b/%b ch_locked=%b/%b locked=%b/%b (got/required)",
                 j, bus.tick, m_tick, bus.ch_locked, m_chl, bus.locked, m_lk);
      end
      c0 += int'(bus.tick[0]);
    end
    checks++;
    if (c0 != 0) begin errors++; $display("FAIL step0_silent: %0d ch0 ticks, required 0", c0); end
  endtask

  task automatic test_zero_to_nonzero();
    int c0 = 0;
    bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_step = 8'd64;
    cyc();
    drive_idle();
    checks++;
    if (bus.ch_locked[0] !== 1'b0) begin
      errors++; $display("FAIL zero_unlock: ch_locked[0]=%b, required 0", bus.ch_locked[0]);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      checks++;
      if (bus.tick[0] !== (k == 5) || bus.ch_locked[0] !== 1'b1) begin
        errors++;
        $display("FAIL zero_apply k=%0d: tick0=%b ch_locked0=%b, required %0d 1",
                 k, bus.tick[0], bus.ch_locked[0], (k == 5));
      end
    end
    for (int j = 0; j < 16; j++) begin
      cyc();
      c0 += int'(bus.tick[0]);
    end
    checks++;
    if (c0 != 4) begin errors++; $display("FAIL zero_rate: %0d per 16, required 4", c0); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 300; j++) begin
      bus.wr_en     = ($urandom_range(0, 3) == 0);
      bus.wr_ch     = 1'($urandom_range(0, 1));
      bus.wr_step   = 8'($urandom_range(0, 255));
      bus.phase_rst = ($urandom_range(0, 31) == 0);
      cyc();
      checks++;
      if (bus.tick !== m_tick || bus.ch_locked !== m_chl || bus.locked !== m_lk) begin
        errors++;
        $display("FAIL random_model j=%0d: tick=%b/%b ch_locked=%b/%b locked=%b/%b (got/required)",
                 j, bus.tick, m_tick, bus.ch_locked, m_chl, bus.locked, m_lk);
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    int c1 = 0;
    bus.wr_en = 1'b1; bus.wr_ch = 1'b1; bus.wr_step = 8'd200;
    cyc();
    drive_idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= S + 24; k++) begin
      cyc();
      checks++;
      if (bus.tick !== m_tick || bus.ch_locked !== m_chl || bus.locked !== m_lk) begin
        errors++;
        $display("FAIL rstmid_model k=%0d: tick=%b/%b ch_locked=%b/%b locked=%b/%b (got/required)",
                 k, bus.tick, m_tick, bus.ch_locked, m_chl, bus.locked, m_lk);
      end
      if (k <= S) begin
        checks++;
        if (bus.tick !== 2'b00 || bus.ch_locked !== 2'b00 || bus.locked !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_quiet k=%0d: tick=%b ch_locked=%b locked=%b, required 0",
                   k, bus.tick, bus.ch_locked, bus.locked);
        end
      end
      if (k > S + 8) c1 += int'(bus.tick[1]);
    end
    checks++;
    if (c1 != 6) begin errors++; $display("FAIL rstmid_default: %0d ch1 per 16, required 6", c1); end
  endtask

  task automatic test_default_rate();
    int n = 40000;
    int cnt = 0;
    int expv;
    expv = n * 25175 / 100000;
    rst2 = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (bus32.locked !== 1'b1) begin
      errors++; $display("FAIL default_locked: locked=%b, required 1", bus32.locked);
    end
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      cnt += int'(bus32.tick[0]);
    end
    checks++;
    if (cnt < expv - 1 || cnt > expv + 1) begin
      errors++; $display("FAIL default_rate: %0d ticks in %0d cycles, required %0d +-1", cnt, n, expv);
    end
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    drive_idle();
    bus32.wr_en = 1'b0; bus32.wr_ch = '0; bus32.wr_step = '0; bus32.phase_rst = 1'b0;
    test_reset();
    test_startup();
    test_rate_switch();
    test_overwrite();
    test_phase_rst();
    test_zero_to_nonzero();
    test_random();
    test_reset_mid();
    test_default_rate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
